// File: rtl/spi_flash_host.sv
`default_nettype none
// ============================================================================
// Module   : spi_flash_host
// Brief    : SPI mode-0 host issuing fixed 48-bit frames to a serial flash:
//            32-bit address, 8-bit command, 8-bit data, all MSB first.
//            Read frames (Cmd 0x01) capture eight MISO samples into RdData.
// Revision : 1.0 - initial release
// ============================================================================
module spi_flash_host #(
    parameter int DIV = 2                   // SCLK half-period in clk cycles, 1..255
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        Start,
    input  logic [7:0]  Cmd,
    input  logic [31:0] Adr,
    input  logic [7:0]  WrData,
    output logic        Busy,
    output logic        Done,
    output logic [7:0]  RdData,
    output logic        SCLK,
    output logic        CS,
    output logic        MOSI,
    input  logic        MISO
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LEAD    = 3'd1,
        S_XFER_HI = 3'd2,
        S_XFER_LO = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    localparam logic [7:0] c_CNT_LAST   = 8'(DIV - 1);
    localparam logic [5:0] c_LAST_BIT   = 6'd47;
    localparam logic [5:0] c_RD_FIRST   = 6'd39;
    localparam logic [5:0] c_RD_LAST    = 6'd46;
    localparam logic [7:0] c_CMD_READ   = 8'h01;

    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_cnt;       // cycles spent in the current SCLK phase
    logic [5:0]  r_idx;       // bit currently on the wire, 0..47
    logic [47:0] r_shift;     // frame bits; bit 47 is the one being driven
    logic [7:0]  r_cmd;       // command latched at accept, selects read capture
    logic [7:0]  r_rx;        // MISO samples collected during the frame
    logic [7:0]  r_rddata;
    logic        r_mosi;

    logic        w_accept;
    logic        w_phase_end;
    logic        w_fall;      // this edge takes SCLK from 1 to 0
    logic        w_bit_end;   // this edge finishes a low phase

    // A new frame may start from IDLE or from the single DONE cycle.
    assign w_accept    = Start && (r_state == S_IDLE || r_state == S_DONE);
    assign w_phase_end = (r_cnt == c_CNT_LAST);
    assign w_fall      = (r_state == S_XFER_HI) && w_phase_end;
    assign w_bit_end   = (r_state == S_XFER_LO) && w_phase_end;

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state selection: each active phase lasts DIV cycles.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: w_next = Start ? S_LEAD : S_IDLE;
            S_LEAD:         if (w_phase_end) w_next = S_XFER_HI;
            S_XFER_HI:      if (w_phase_end) w_next = S_XFER_LO;
            S_XFER_LO:      if (w_phase_end) w_next = (r_idx == c_LAST_BIT) ? S_DONE : S_XFER_HI;
            default:        w_next = S_IDLE;
        endcase
    end

    // Phase counter, bit index, serial shift paths and read capture.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt    <= 8'd0;
            r_idx    <= 6'd0;
            r_shift  <= 48'd0;
            r_cmd    <= 8'd0;
            r_rx     <= 8'd0;
            r_rddata <= 8'd0;
            r_mosi   <= 1'b0;
        end else begin
            if (r_state != w_next) begin
                r_cnt <= 8'd0;
            end else if (r_state == S_LEAD || r_state == S_XFER_HI || r_state == S_XFER_LO) begin
                r_cnt <= r_cnt + 8'd1;
            end

            if (w_accept) begin
                r_shift <= {Adr, Cmd, WrData};
                r_cmd   <= Cmd;
                r_mosi  <= Adr[31];
                r_idx   <= 6'd0;
                r_rx    <= 8'd0;
            end

            // MOSI moves only on the falling SCLK edge; zeros shifted in
            // make the line return low after the last bit.
            if (w_fall) begin
                r_shift <= {r_shift[46:0], 1'b0};
                r_mosi  <= r_shift[46];
                if (r_cmd == c_CMD_READ && r_idx >= c_RD_FIRST && r_idx <= c_RD_LAST) begin
                    r_rx <= {r_rx[6:0], MISO};
                end
            end

            if (w_bit_end) begin
                if (r_idx != c_LAST_BIT) begin
                    r_idx <= r_idx + 6'd1;
                end else if (r_cmd == c_CMD_READ) begin
                    r_rddata <= r_rx;
                end
            end
        end
    end

    assign CS     = !(r_state == S_LEAD || r_state == S_XFER_HI || r_state == S_XFER_LO);
    assign Busy   = !CS;
    assign SCLK   = (r_state == S_XFER_HI);
    assign Done   = (r_state == S_DONE);
    assign MOSI   = r_mosi;
    assign RdData = r_rddata;

endmodule
`default_nettype wire

// File: tb/tb_spi_flash_host.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_flash_host
// Brief    : Self-checking bench for spi_flash_host at DIV=1 and DIV=4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_flash_host;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start1, start4;
    logic [7:0]  cmd;
    logic [31:0] adr;
    logic [7:0]  wrdata;
    logic        miso;

    logic        busy1, done1, sclk1, cs1, mosi1;
    logic [7:0]  rd1;
    logic        busy4, done4, sclk4, cs4, mosi4;
    logic [7:0]  rd4;

    logic        sel4;
    logic        o_cs, o_sclk, o_mosi, o_busy, o_done;
    logic [7:0]  o_rd;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    spi_flash_host #(.DIV(1)) u_dut1 (
        .clk(clk), .resetn(resetn), .Start(start1), .Cmd(cmd), .Adr(adr), .WrData(wrdata),
        .Busy(busy1), .Done(done1), .RdData(rd1), .SCLK(sclk1), .CS(cs1), .MOSI(mosi1), .MISO(miso)
    );

    spi_flash_host #(.DIV(4)) u_dut4 (
        .clk(clk), .resetn(resetn), .Start(start4), .Cmd(cmd), .Adr(adr), .WrData(wrdata),
        .Busy(busy4), .Done(done4), .RdData(rd4), .SCLK(sclk4), .CS(cs4), .MOSI(mosi4), .MISO(miso)
    );

    assign o_cs   = sel4 ? cs4   : cs1;
    assign o_sclk = sel4 ? sclk4 : sclk1;
    assign o_mosi = sel4 ? mosi4 : mosi1;
    assign o_busy = sel4 ? busy4 : busy1;
    assign o_done = sel4 ? done4 : done1;
    assign o_rd   = sel4 ? rd4   : rd1;

    typedef struct {
        logic [7:0]  cmd;
        logic [31:0] adr;
        logic [7:0]  wr;
        logic [7:0]  pat;     // byte the responder returns on MISO
        logic [7:0]  exp_rd;  // RdData expected after the frame
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Runs one frame on the selected DUT. Must be called just after a negedge.
    task automatic run_frame(input int div, input logic [7:0] c, input logic [31:0] a,
                             input logic [7:0] w, input logic [7:0] pat,
                             input logic [7:0] exp_rd, input int glitch_at, input string tag);
        int cs_low, done_at, done_cnt, rises, bad_ph, mosi_chg, busy_bad, hi_run, lo_run;
        logic [47:0] got;
        logic prev_sclk, prev_mosi, prev_cs;
        cmd = c; adr = a; wrdata = w;
        if (sel4) start4 = 1'b1; else start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0; start4 = 1'b0;
        cmd = ~c; adr = ~a; wrdata = ~w;
        cs_low = 0; done_at = 0; done_cnt = 0; rises = 0; bad_ph = 0; mosi_chg = 0;
        busy_bad = 0; hi_run = 0; lo_run = 0; got = '0;
        prev_sclk = 1'b0; prev_mosi = 1'b0; prev_cs = 1'b1;
        for (int k = 1; k <= 97 * div + 20; k++) begin
            @(negedge clk);
            if (!o_cs) cs_low++;
            if (o_busy !== !o_cs) busy_bad++;
            if (o_sclk && !prev_sclk) begin
                got  = {got[46:0], o_mosi};
                miso = (rises >= 39 && rises <= 46) ? pat[46 - rises] : 1'b0;
                rises++;
                if (lo_run != div) bad_ph++;
                lo_run = 0;
            end
            if (!o_sclk && prev_sclk) begin
                if (hi_run != div) bad_ph++;
                hi_run = 0;
            end
            if (o_cs && !prev_cs) begin
                if (lo_run != div) bad_ph++;
                lo_run = 0;
            end
            if (o_sclk) hi_run++;
            else if (!o_cs) lo_run++;
            if (k > 1 && o_mosi !== prev_mosi && !(prev_sclk && !o_sclk)) mosi_chg++;
            if (o_done) begin
                done_cnt++;
                if (done_at == 0) done_at = k;
            end
            prev_sclk = o_sclk; prev_mosi = o_mosi; prev_cs = o_cs;
            if (sel4) start4 = (k == glitch_at); else start1 = (k == glitch_at);
        end
        start1 = 1'b0; start4 = 1'b0;
        miso = 1'b0;
        check({tag, " cs_low_cycles"}, 64'(cs_low), 64'(97 * div));
        check({tag, " done_latency"}, 64'(done_at), 64'(97 * div + 1));
        check({tag, " done_pulses"}, 64'(done_cnt), 64'd1);
        check({tag, " sclk_rises"}, 64'(rises), 64'd48);
        check({tag, " mosi_bits"}, 64'(got), 64'({a, c, w}));
        check({tag, " phase_len_errs"}, 64'(bad_ph), 64'd0);
        check({tag, " mosi_off_fall"}, 64'(mosi_chg), 64'd0);
        check({tag, " busy_vs_cs"}, 64'(busy_bad), 64'd0);
        check({tag, " rddata"}, 64'(o_rd), 64'(exp_rd));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, gap_ok, rises;
        logic done_seen;
        vecs[0] = '{cmd: 8'h02, adr: 32'h0000_0003, wr: 8'hA5, pat: 8'h00, exp_rd: 8'h00};
        vecs[1] = '{cmd: 8'h01, adr: 32'h1234_5678, wr: 8'h00, pat: 8'h3C, exp_rd: 8'h3C};
        vecs[2] = '{cmd: 8'h00, adr: 32'hFFFF_FFFF, wr: 8'h5A, pat: 8'hFF, exp_rd: 8'h3C};
        vecs[3] = '{cmd: 8'h01, adr: 32'h8000_0001, wr: 8'hFF, pat: 8'h81, exp_rd: 8'h81};
        vecs[4] = '{cmd: 8'hC3, adr: 32'hA5A5_0F0F, wr: 8'h96, pat: 8'h00, exp_rd: 8'h81};

        sel4 = 1'b0; start1 = 1'b0; start4 = 1'b0; miso = 1'b0;
        cmd = 8'h00; adr = 32'h0; wrdata = 8'h00;
        resetn = 1'b1;
        #1 resetn = 1'b0;
        #2;
        // Reset state, observed before any clock edge.
        check("rst cs1",   64'(cs1),   64'd1);
        check("rst sclk1", 64'(sclk1), 64'd0);
        check("rst mosi1", 64'(mosi1), 64'd0);
        check("rst busy1", 64'(busy1), 64'd0);
        check("rst done1", 64'(done1), 64'd0);
        check("rst rd1",   64'(rd1),   64'd0);
        check("rst cs4",   64'(cs4),   64'd1);
        check("rst sclk4", 64'(sclk4), 64'd0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            run_frame(1, vecs[i].cmd, vecs[i].adr, vecs[i].wr, vecs[i].pat, vecs[i].exp_rd,
                      0, $sformatf("vec%0d", i));
        end

        // DIV=4 frame with a stray Start mid-frame that must be dropped.
        sel4 = 1'b1;
        run_frame(4, 8'h02, 32'hDEAD_BEEF, 8'h3C, 8'h00, 8'h00, 50, "div4");
        sel4 = 1'b0;

        // Back-to-back: Start held high through DONE.
        cmd = 8'h02; adr = 32'h0000_0040; wrdata = 8'h11; start1 = 1'b1;
        done_seen = 1'b0; n = 0;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (done1) begin done_seen = 1'b1; n = k; break; end
        end
        check("b2b first_done", 64'(n), 64'd98);
        check("b2b cs_in_done", 64'(cs1), 64'd1);
        @(negedge clk);
        check("b2b cs_after_gap", 64'(cs1), 64'd0);
        start1 = 1'b0;
        n = 0;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (done1) begin n = k; break; end
        end
        check("b2b second_done", 64'(n), 64'd97);
        repeat (3) @(negedge clk);
        check("b2b idle_after", 64'(cs1), 64'd1);

        // Reset in the middle of a read frame at bit index 20.
        cmd = 8'h01; adr = 32'h0F0F_0F0F; wrdata = 8'h00; start1 = 1'b1;
        @(posedge clk); #1 start1 = 1'b0;
        rises = 0; gap_ok = 0;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (sclk1) rises++;
            if (rises == 21) begin gap_ok = 1; break; end
        end
        check("midrst reached_bit20", 64'(gap_ok), 64'd1);
        #2 resetn = 1'b0;
        #1;
        check("midrst cs",   64'(cs1),   64'd1);
        check("midrst sclk", 64'(sclk1), 64'd0);
        check("midrst busy", 64'(busy1), 64'd0);
        check("midrst rd",   64'(rd1),   64'd0);
        n = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (done1) n++;
        end
        check("midrst no_done", 64'(n), 64'd0);
        resetn = 1'b1;
        run_frame(1, 8'h01, 32'h0000_0100, 8'h00, 8'h96, 8'h96, 0, "post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
